// File: rtl/benes_perm_decoder.sv
`default_nettype none
// ============================================================================
// benes_perm_decoder : turns a Benes control word back into its permutation,
// evaluating one switch stage per clock. BENES_DEC_INV_EN adds inv_out.
// Revision: 1.0
// ============================================================================
module benes_perm_decoder #(
  parameter  int SIZE     = 32,
  localparam int TAGWIDTH = $clog2(SIZE),
  localparam int STAGES   = 2 * TAGWIDTH - 1,
  localparam int BITWIDTH = STAGES * (SIZE >> 1),
  localparam int CNTW     = $clog2(STAGES + 1)
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [BITWIDTH-1:0]      ctrl_in,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SIZE*TAGWIDTH-1:0] perm_out,
`ifdef BENES_DEC_INV_EN
  output logic [SIZE*TAGWIDTH-1:0] inv_out,
`endif
  output logic                     busy,
  output logic [CNTW-1:0]          stage_cnt
);

  localparam int HALF = SIZE / 2;

`ifdef BENES_DEC_INV_EN
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2, INV = 2'd3} state_e;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;
`endif

  state_e                state_q, state_d;
  logic [CNTW-1:0]       stage_cnt_q, stage_cnt_d;
  logic [BITWIDTH-1:0]   ctrl_q, ctrl_d;
  logic [TAGWIDTH-1:0]   tag_q  [SIZE];
  logic [TAGWIDTH-1:0]   tag_d  [SIZE];
  logic [TAGWIDTH-1:0]   perm_q [SIZE];
  logic [TAGWIDTH-1:0]   perm_d [SIZE];
  logic [TAGWIDTH-1:0]   sw     [SIZE];
  logic [TAGWIDTH-1:0]   wired  [SIZE];
  logic [HALF-1:0]       stage_sel;
`ifdef BENES_DEC_INV_EN
  logic [TAGWIDTH-1:0]   inv_q  [SIZE];
  logic [TAGWIDTH-1:0]   inv_d  [SIZE];
`endif

  // One stage: switch column, then the inter-stage wiring for that stage.
  // blk == 0 marks the last stage, which has no wiring after its switches.
  always_comb begin
    int  blk;
    int  loc;
    int  dst;
    logic unshuf;
    blk       = 0;
    loc       = 0;
    dst       = 0;
    unshuf    = (int'(stage_cnt_q) < TAGWIDTH - 1);
    stage_sel = ctrl_q[int'(stage_cnt_q) * HALF +: HALF];
    if (unshuf) begin
      blk = SIZE >> stage_cnt_q;
    end else if (int'(stage_cnt_q) < STAGES - 1) begin
      blk = SIZE >> (STAGES - 2 - int'(stage_cnt_q));
    end
    for (int i = 0; i < SIZE; i++) begin
      sw[i] = stage_sel[i / 2] ? tag_q[i ^ 1] : tag_q[i];
    end
    for (int i = 0; i < SIZE; i++) begin
      wired[i] = sw[i];
    end
    if (blk != 0) begin
      for (int i = 0; i < SIZE; i++) begin
        loc = i & (blk - 1);
        if (unshuf) begin
          dst = (i - loc) + (loc >> 1) + (loc & 1) * (blk / 2);
        end else begin
          dst = (i - loc) + (loc & (blk / 2 - 1)) * 2 + ((loc >= blk / 2) ? 1 : 0);
        end
        wired[dst] = sw[i];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    stage_cnt_d = stage_cnt_q;
    ctrl_d      = ctrl_q;
    tag_d       = tag_q;
    perm_d      = perm_q;
`ifdef BENES_DEC_INV_EN
    inv_d       = inv_q;
`endif
    if (flush) begin
      state_d     = IDLE;
      stage_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            ctrl_d      = ctrl_in;
            stage_cnt_d = '0;
            state_d     = RUN;
            for (int i = 0; i < SIZE; i++) begin
              tag_d[i] = TAGWIDTH'(i);
            end
          end
        end
        RUN: begin
          tag_d = wired;
          if (stage_cnt_q == CNTW'(STAGES - 1)) begin
            perm_d = wired;
`ifdef BENES_DEC_INV_EN
            state_d = INV;
`else
            state_d = DONE;
`endif
          end else begin
            stage_cnt_d = stage_cnt_q + CNTW'(1);
          end
        end
`ifdef BENES_DEC_INV_EN
        INV: begin
          for (int j = 0; j < SIZE; j++) begin
            inv_d[perm_q[j]] = TAGWIDTH'(j);
          end
          state_d = DONE;
        end
`endif
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      stage_cnt_q <= '0;
      ctrl_q      <= '0;
      for (int i = 0; i < SIZE; i++) begin
        tag_q[i]  <= '0;
        perm_q[i] <= '0;
`ifdef BENES_DEC_INV_EN
        inv_q[i]  <= '0;
`endif
      end
    end else begin
      state_q     <= state_d;
      stage_cnt_q <= stage_cnt_d;
      ctrl_q      <= ctrl_d;
      tag_q       <= tag_d;
      perm_q      <= perm_d;
`ifdef BENES_DEC_INV_EN
      inv_q       <= inv_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN);
  assign stage_cnt = stage_cnt_q;

  for (genvar j = 0; j < SIZE; j++) begin : g_flat
    assign perm_out[j*TAGWIDTH +: TAGWIDTH] = perm_q[j];
`ifdef BENES_DEC_INV_EN
    assign inv_out[j*TAGWIDTH +: TAGWIDTH]  = inv_q[j];
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_benes_perm_decoder.sv
`default_nettype none
// Bench for benes_perm_decoder: a looping-algorithm Benes router encodes random
// permutations, the decoder must hand them back; protocol scenarios follow.
module tb_benes_perm_decoder;
  localparam int SIZE   = 32;
  localparam int TW     = 5;
  localparam int STAGES = 9;
  localparam int H      = SIZE / 2;
  localparam int BW     = STAGES * H;
  localparam int CW     = 4;
`ifdef BENES_DEC_INV_EN
  localparam int LAT = STAGES + 1;
`else
  localparam int LAT = STAGES;
`endif

  typedef int perm_t [SIZE];

  logic              clk = 1'b0;
  logic              n_rst;
  logic              in_valid;
  logic              in_ready;
  logic [BW-1:0]     ctrl_in;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [SIZE*TW-1:0] perm_out;
`ifdef BENES_DEC_INV_EN
  logic [SIZE*TW-1:0] inv_out;
`endif
  logic              busy;
  logic [CW-1:0]     stage_cnt;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  benes_perm_decoder #(.SIZE(SIZE)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ctrl_in   (ctrl_in),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .perm_out  (perm_out),
`ifdef BENES_DEC_INV_EN
    .inv_out   (inv_out),
`endif
    .busy      (busy),
    .stage_cnt (stage_cnt)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic unpack_vec(input logic [SIZE*TW-1:0] v, output perm_t r);
    for (int j = 0; j < SIZE; j++) r[j] = int'(v[j*TW +: TW]);
  endtask

  task automatic rand_perm(output perm_t p);
    int j, t;
    for (int i = 0; i < SIZE; i++) p[i] = i;
    for (int i = SIZE - 1; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      t = p[i]; p[i] = p[j]; p[j] = t;
    end
  endtask

  // Recursive Benes routing done level by level: at level L the network is a
  // set of sub-networks of size SIZE>>L; dst holds each input's local target.
  task automatic encode(input perm_t p, output logic [BW-1:0] c);
    int dst [SIZE];
    int nd  [SIZE];
    int inv [SIZE];
    int sub [SIZE];
    bit asg [SIZE];
    int n, a, b, d;
    c = '0;
    for (int j = 0; j < SIZE; j++) dst[p[j]] = j;
    for (int j = 0; j < SIZE; j++) nd[j] = 0;
    for (int lv = 0; lv < TW; lv++) begin
      n = SIZE >> lv;
      for (int base = 0; base < SIZE; base += n) begin
        if (n == 2) begin
          c[lv*H + base/2] = (dst[base] != 0);
        end else begin
          for (int k = 0; k < n; k++) begin
            inv[dst[base+k]] = k;
            asg[k] = 1'b0;
            sub[k] = 0;
          end
          for (int a0 = 0; a0 < n; a0++) begin
            a = a0;
            while (!asg[a]) begin
              asg[a] = 1'b1; sub[a] = 0;
              b = inv[dst[base+a] ^ 1];
              asg[b] = 1'b1; sub[b] = 1;
              a = b ^ 1;
            end
          end
          for (int i = 0; i < n/2; i++) c[lv*H + base/2 + i] = (sub[2*i] != 0);
          for (int k = 0; k < n; k++) begin
            d = dst[base+k];
            c[(STAGES-1-lv)*H + base/2 + d/2] = ((d & 1) != sub[k]);
            nd[base + sub[k]*(n/2) + k/2] = d >> 1;
          end
        end
      end
      dst = nd;
    end
  endtask

  // One full transaction with out_ready held high; lat counts clocks from accept.
  task automatic run_decode(input logic [BW-1:0] c, output perm_t got, output perm_t inv_got,
                            output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin tick; guard++; end
    in_valid = 1'b1; ctrl_in = c; out_ready = 1'b1;
    tick;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 60) begin tick; lat++; end
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL run_timeout: out_valid=%b after %0d clocks, required 1", out_valid, lat);
    end
    unpack_vec(perm_out, got);
`ifdef BENES_DEC_INV_EN
    unpack_vec(inv_out, inv_got);
`else
    for (int j = 0; j < SIZE; j++) inv_got[j] = 0;
`endif
    tick;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    n_rst = 1'b0; in_valid = 1'b0; ctrl_in = '0; flush = 1'b0; out_ready = 1'b0;
    repeat (2) tick;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b need 1", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b need 0", out_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b need 0", busy); end
    vectors++; if (stage_cnt !== '0) begin miscompares++; $display("FAIL reset_stage_cnt: got %0d need 0", stage_cnt); end
    vectors++; if (perm_out !== '0) begin miscompares++; $display("FAIL reset_perm_out: got %h need 0", perm_out); end
    n_rst = 1'b1;
    tick;
  endtask

  task automatic test_identity;
    perm_t got, ig; int lat; int bad;
    run_decode('0, got, ig, lat);
    vectors++; if (lat !== LAT) begin miscompares++; $display("FAIL identity_latency: got %0d need %0d", lat, LAT); end
    bad = -1;
    for (int j = 0; j < SIZE; j++) if (got[j] != j && bad < 0) bad = j;
    vectors++; if (bad >= 0) begin miscompares++; $display("FAIL identity_perm: perm[%0d]=%0d need %0d", bad, got[bad], bad); end
  endtask

  task automatic test_single_bits;
    perm_t got, ig, exp; int lat; int bad; logic [BW-1:0] c;
    int bitpos [2];
    int other  [2];
    bitpos[0] = 0;  other[0] = 1;
    bitpos[1] = 64; other[1] = 16;
    for (int t = 0; t < 2; t++) begin
      c = '0; c[bitpos[t]] = 1'b1;
      for (int j = 0; j < SIZE; j++) exp[j] = j;
      exp[0] = other[t]; exp[other[t]] = 0;
      run_decode(c, got, ig, lat);
      bad = -1;
      for (int j = 0; j < SIZE; j++) if (got[j] != exp[j] && bad < 0) bad = j;
      vectors++; if (bad >= 0) begin miscompares++; $display("FAIL single_bit%0d: perm[%0d]=%0d need %0d", bitpos[t], bad, got[bad], exp[bad]); end
      vectors++; if (lat !== LAT) begin miscompares++; $display("FAIL single_bit%0d_latency: got %0d need %0d", bitpos[t], lat, LAT); end
`ifdef BENES_DEC_INV_EN
      bad = -1;
      for (int j = 0; j < SIZE; j++) if (ig[exp[j]] != j && bad < 0) bad = exp[j];
      vectors++; if (bad >= 0) begin miscompares++; $display("FAIL single_bit%0d_inv: inv[%0d]=%0d wrong", bitpos[t], bad, ig[bad]); end
`endif
    end
  endtask

  task automatic test_random_roundtrip;
    perm_t p, got, ig; logic [BW-1:0] c; int lat; int bad;
    for (int it = 0; it < 200; it++) begin
      rand_perm(p);
      encode(p, c);
      run_decode(c, got, ig, lat);
      bad = -1;
      for (int j = 0; j < SIZE; j++) if (got[j] != p[j] && bad < 0) bad = j;
      vectors++; if (bad >= 0) begin miscompares++; $display("FAIL roundtrip[%0d]: perm[%0d]=%0d need %0d", it, bad, got[bad], p[bad]); end
`ifdef BENES_DEC_INV_EN
      bad = -1;
      for (int j = 0; j < SIZE; j++) if (ig[p[j]] != j && bad < 0) bad = p[j];
      vectors++; if (bad >= 0) begin miscompares++; $display("FAIL roundtrip_inv[%0d]: inv[%0d]=%0d wrong", it, bad, ig[bad]); end
`endif
    end
  endtask

  task automatic test_random_words;
    perm_t got, ig; logic [BW-1:0] c; int lat; int cnt [SIZE]; bit ok;
    for (int it = 0; it < 20; it++) begin
      for (int b = 0; b < BW; b++) c[b] = 1'($urandom_range(1, 0));
      run_decode(c, got, ig, lat);
      for (int j = 0; j < SIZE; j++) cnt[j] = 0;
      for (int j = 0; j < SIZE; j++) cnt[got[j]]++;
      ok = 1'b1;
      for (int j = 0; j < SIZE; j++) if (cnt[j] != 1) ok = 1'b0;
      vectors++; if (!ok) begin miscompares++; $display("FAIL random_word_perm[%0d]: perm_out=%h is not a permutation", it, perm_out); end
    end
  endtask

  task automatic test_backpressure;
    perm_t p1, p2, got; logic [BW-1:0] c1, c2; logic [SIZE*TW-1:0] held;
    int n, bad; bit stable, blocked;
    rand_perm(p1); encode(p1, c1);
    rand_perm(p2); encode(p2, c2);
    out_ready = 1'b0; in_valid = 1'b1; ctrl_in = c1;
    tick;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 60) begin tick; n++; end
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_first_valid: got %b need 1", out_valid); end
    held = perm_out;
    unpack_vec(perm_out, got);
    bad = -1;
    for (int j = 0; j < SIZE; j++) if (got[j] != p1[j] && bad < 0) bad = j;
    vectors++; if (bad >= 0) begin miscompares++; $display("FAIL bp_first_perm: perm[%0d]=%0d need %0d", bad, got[bad], p1[bad]); end
    in_valid = 1'b1; ctrl_in = c2;
    stable = 1'b1; blocked = 1'b1;
    repeat (5) begin
      tick;
      if (perm_out !== held || out_valid !== 1'b1) stable = 1'b0;
      if (in_ready !== 1'b0 || busy !== 1'b0) blocked = 1'b0;
    end
    vectors++; if (!stable) begin miscompares++; $display("FAIL bp_hold: perm_out=%h out_valid=%b need %h and 1", perm_out, out_valid, held); end
    vectors++; if (!blocked) begin miscompares++; $display("FAIL bp_blocked: in_ready=%b busy=%b need 0 0", in_ready, busy); end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++; $display("FAIL bp_handshake: out_valid=%b in_ready=%b busy=%b need 0 1 0", out_valid, in_ready, busy);
    end
    tick;
    in_valid = 1'b0;
    vectors++; if (busy !== 1'b1 || stage_cnt !== '0) begin
      miscompares++; $display("FAIL bp_second_accept: busy=%b stage_cnt=%0d need 1 0", busy, stage_cnt);
    end
    n = 0;
    while (!out_valid && n < 60) begin tick; n++; end
    vectors++; if (n !== LAT) begin miscompares++; $display("FAIL bp_second_latency: got %0d need %0d", n, LAT); end
    unpack_vec(perm_out, got);
    bad = -1;
    for (int j = 0; j < SIZE; j++) if (got[j] != p2[j] && bad < 0) bad = j;
    vectors++; if (bad >= 0) begin miscompares++; $display("FAIL bp_second_perm: perm[%0d]=%0d need %0d", bad, got[bad], p2[bad]); end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
  endtask

  task automatic test_flush;
    perm_t p; logic [BW-1:0] c; logic [SIZE*TW-1:0] prev; int n; bit seen;
    prev = perm_out;
    rand_perm(p); encode(p, c);
    in_valid = 1'b1; ctrl_in = c; out_ready = 1'b1;
    tick;
    in_valid = 1'b0;
    n = 0;
    while (stage_cnt !== CW'(3) && n < 20) begin tick; n++; end
    vectors++; if (stage_cnt !== CW'(3) || busy !== 1'b1) begin
      miscompares++; $display("FAIL flush_reach_stage3: stage_cnt=%0d busy=%b need 3 1", stage_cnt, busy);
    end
    flush = 1'b1;
    tick;
    flush = 1'b0;
    vectors++; if (busy !== 1'b0 || in_ready !== 1'b1 || stage_cnt !== '0 || out_valid !== 1'b0) begin
      miscompares++; $display("FAIL flush_idle: busy=%b in_ready=%b stage_cnt=%0d out_valid=%b need 0 1 0 0", busy, in_ready, stage_cnt, out_valid);
    end
    vectors++; if (perm_out !== prev) begin miscompares++; $display("FAIL flush_perm_kept: got %h need %h", perm_out, prev); end
    seen = 1'b0;
    repeat (15) begin tick; if (out_valid !== 1'b0) seen = 1'b1; end
    vectors++; if (seen) begin miscompares++; $display("FAIL flush_no_valid: out_valid pulsed=1 need 0"); end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run;
    perm_t p; logic [BW-1:0] c; bit seen;
    rand_perm(p); encode(p, c);
    in_valid = 1'b1; ctrl_in = c; out_ready = 1'b1;
    tick;
    in_valid = 1'b0;
    repeat (4) tick;
    n_rst = 1'b0;
    #1;
    vectors++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL midrun_reset_ctrl: in_ready=%b out_valid=%b busy=%b need 1 0 0", in_ready, out_valid, busy);
    end
    vectors++; if (stage_cnt !== '0) begin miscompares++; $display("FAIL midrun_reset_stage_cnt: got %0d need 0", stage_cnt); end
    vectors++; if (perm_out !== '0) begin miscompares++; $display("FAIL midrun_reset_perm: got %h need 0", perm_out); end
`ifdef BENES_DEC_INV_EN
    vectors++; if (inv_out !== '0) begin miscompares++; $display("FAIL midrun_reset_inv: got %h need 0", inv_out); end
`endif
    tick;
    n_rst = 1'b1;
    seen = 1'b0;
    repeat (15) begin tick; if (out_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1; end
    vectors++; if (seen) begin miscompares++; $display("FAIL midrun_no_result: activity after reset, need idle"); end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset;
    test_identity;
    test_single_bits;
    test_random_roundtrip;
    test_random_words;
    test_backpressure;
    test_flush;
    test_reset_mid_run;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
